// File: rtl/mf_clken_pkg.sv
// rtl/mf_clken_pkg.sv - shared types and constants for the mf_clken_gen clock-enable generator
//
// Contents:
//   state_t            - controller state (WAIT_LOCK / SETTLE / RUN), 2-bit encoding
//   DEF_*              - default parameter values for mf_clken_gen
//   DIV4 / DIV6 / DIV8 - div_sel codes (ratio minus one) for the common dot-clock ratios
package mf_clken_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_CNT_W         = 4;
  localparam int DEF_SETTLE_CYCLES = 256;
  localparam int DEF_SETTLE_W      = 9;

  localparam int DIV4 = 3;
  localparam int DIV6 = 5;
  localparam int DIV8 = 7;

endpackage

// File: rtl/mf_clken_chan.sv
// rtl/mf_clken_chan.sv - one clock-enable channel: divider counter, shadow ratio/phase, enables
//
// Ports:
//   clk        in   refclk
//   rst        in   asynchronous active-high reset
//   run        in   controller is in RUN (registered state)
//   load       in   clear the counter and load the shadows now (RUN entry or resync)
//   clr        in   leaving RUN this edge: clear the counter
//   div_sel    in   divide ratio minus one
//   phase_sel  in   ce_ph offset from period start, clamped to the divisor
//   ce         out  one-cycle enable at the end of each divided period
//   ce_ph      out  phase-shifted enable
module mf_clken_chan
  import mf_clken_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic             clr,
  input  logic [CNT_W-1:0] div_sel,
  input  logic [CNT_W-1:0] phase_sel,
  output logic             ce,
  output logic             ce_ph
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] ph_q;
  logic [CNT_W-1:0] ph_eff;
  logic             wrap;

  assign wrap = (cnt == div_q);

  // Shadows only move at a period boundary (or an explicit load), so a
  // retune never produces a runt or stretched period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
      ph_q  <= '0;
    end else if (load) begin
      cnt   <= '0;
      div_q <= div_sel;
      ph_q  <= phase_sel;
    end else if (clr || !run) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt   <= '0;
      div_q <= div_sel;
      ph_q  <= phase_sel;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A phase beyond the period end lands on the last cycle, coinciding with ce.
  assign ph_eff = (ph_q > div_q) ? div_q : ph_q;

  assign ce    = run && wrap;
  assign ce_ph = run && (cnt == ph_eff);

endmodule

// File: rtl/mf_clken_gen.sv
// rtl/mf_clken_gen.sv - multi-channel clock-enable generator gated by a debounced PLL lock
//
// Optional feature macro: MF_CLKEN_SYNC_EN adds the sync_req input, which in RUN
// restarts every channel period together and reloads the shadow ratios.
//
// Ports:
//   refclk      in   master clock from the PLL (only clock)
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock flag, asynchronous to refclk
//   div_sel     in   NUM_CH x CNT_W, per-channel ratio minus one, channel i at [i*CNT_W +: CNT_W]
//   phase_sel   in   NUM_CH x CNT_W, per-channel ce_ph offset in refclk cycles
//   sync_req    in   (MF_CLKEN_SYNC_EN only) common period restart, honoured in RUN
//   ce          out  NUM_CH on-phase enables
//   ce_ph       out  NUM_CH phase-shifted enables
//   ready       out  high while in RUN
module mf_clken_gen
  import mf_clken_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SETTLE_W      = DEF_SETTLE_W
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*CNT_W-1:0] div_sel,
  input  logic [NUM_CH*CNT_W-1:0] phase_sel,
`ifdef MF_CLKEN_SYNC_EN
  input  logic                    sync_req,
`endif
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       ce_ph,
  output logic                    ready
);

  state_t              state;
  logic                sync1;
  logic                locked_s;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                settle_done;
  logic                run;
  logic                enter_run;
  logic                leave_run;
  logic                chan_load;

  assign settle_done = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
  assign run         = (state == RUN);
  assign enter_run   = (state == SETTLE) && locked_s && settle_done;
  assign leave_run   = run && !locked_s;

`ifdef MF_CLKEN_SYNC_EN
  assign chan_load = enter_run || (run && sync_req);
`else
  assign chan_load = enter_run;
`endif

  // Two-flop synchroniser for the asynchronous lock flag, then the lock FSM.
  // ready is registered alongside the state so it tracks RUN exactly.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      locked_s   <= 1'b0;
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      ready      <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
      case (state)
        WAIT_LOCK: begin
          ready <= 1'b0;
          if (locked_s) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
          end else if (settle_done) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    mf_clken_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (refclk),
      .rst      (rst),
      .run      (run),
      .load     (chan_load),
      .clr      (leave_run),
      .div_sel  (div_sel[i*CNT_W +: CNT_W]),
      .phase_sel(phase_sel[i*CNT_W +: CNT_W]),
      .ce       (ce[i]),
      .ce_ph    (ce_ph[i])
    );
  end

endmodule

// File: tb/tb_mf_clken_gen.sv
// tb/tb_mf_clken_gen.sv - scoreboard bench for mf_clken_gen (4 channels, 16-cycle settle)
module tb_mf_clken_gen;
  import mf_clken_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 4;

  logic            refclk = 1'b0;
  logic            rst;
  logic            pll_locked;
  logic [NCH*CW-1:0] div_sel;
  logic [NCH*CW-1:0] phase_sel;
  logic            sync_req;
  logic [NCH-1:0]  ce;
  logic [NCH-1:0]  ce_ph;
  logic            ready;

  logic [CW-1:0] div_in [NCH];
  logic [CW-1:0] ph_in  [NCH];

  // kind: 0 = ce, 1 = ce_ph, 2 = ready rise, 3 = ready fall
  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  passed = 0;
  int  total = 0;
  logic prev_ready = 1'b0;

  int dv [NCH];
  int ph [NCH];
  int anc[NCH];

  mf_clken_gen #(
    .NUM_CH       (NCH),
    .CNT_W        (CW),
    .SETTLE_CYCLES(16),
    .SETTLE_W     (5)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .div_sel   (div_sel),
    .phase_sel (phase_sel),
`ifdef MF_CLKEN_SYNC_EN
    .sync_req  (sync_req),
`endif
    .ce        (ce),
    .ce_ph     (ce_ph),
    .ready     (ready)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  always_comb begin
    div_sel   = '0;
    phase_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      div_sel[i*CW +: CW]   = div_in[i];
      phase_sel[i*CW +: CW] = ph_in[i];
    end
  end

  task automatic push(input int c, input int k, input int ch);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  // Expected enables from the period definition: period d+1 anchored at anc,
  // ce on the last cycle, ce_ph on min(phase, d).
  task automatic gen(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        int k;
        int m;
        int pe;
        k = c - anc[ch];
        if (k >= 0) begin
          m  = k % (dv[ch] + 1);
          pe = (ph[ch] > dv[ch]) ? dv[ch] : ph[ch];
          if (m == dv[ch]) push(c, 0, ch);
          if (m == pe) push(c, 1, ch);
        end
      end
    end
  endtask

  task automatic chk(input int k, input int ch);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event kind=%0d ch=%0d cyc=%0d (none expected)", k, ch, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc == cyc && e.kind == k && e.ch == ch)
        passed++;
      else
        $display("FAIL event_order got kind=%0d ch=%0d cyc=%0d expected kind=%0d ch=%0d cyc=%0d",
                 k, ch, cyc, e.kind, e.ch, e.cyc);
    end
  endtask

  // Monitor: every visible output activity pops one scoreboard entry.
  always @(negedge refclk) begin
    if (ready !== prev_ready) begin
      chk((ready === 1'b1) ? 2 : 3, -1);
      prev_ready = ready;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (ce[ch] !== 1'b0) chk(0, ch);
      if (ce_ph[ch] !== 1'b0) chk(1, ch);
    end
  end

  task automatic wait_edge(input int t);
    while (cyc < t) begin
      @(posedge refclk);
      #1;
    end
  endtask

  initial begin
    int s, d, r, s2, x;
    ev_t e;
    rst        = 1'b1;
    pll_locked = 1'b0;
    sync_req   = 1'b0;
    div_in[0] = CW'(DIV4); div_in[1] = CW'(DIV6); div_in[2] = CW'(DIV8); div_in[3] = 4'd1;
    ph_in[0]  = 4'd0;      ph_in[1]  = 4'd0;      ph_in[2]  = 4'd0;      ph_in[3]  = 4'd5;
    repeat (3) @(posedge refclk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge refclk);
    #1;

    // Lock at edge 0: ready on edge 19; ch0 retuned 3 -> 7 in RUN cycle 1.
    pll_locked = 1'b1;
    s = cyc + 19;
    d = s + 24;
    dv[0] = 3; dv[1] = 5; dv[2] = 7; dv[3] = 1;
    ph[0] = 0; ph[1] = 0; ph[2] = 0; ph[3] = 5;
    for (int i = 0; i < NCH; i++) anc[i] = s;
    push(s, 2, -1);
    gen(s, s + 3);
    dv[0]  = 7;
    anc[0] = s + 4;
    gen(s + 4, d + 2);
    push(d + 3, 3, -1);
    wait_edge(s + 1);
    div_in[0] = 4'd7;

    // Lock lost mid-period: enables and ready fall three edges later.
    wait_edge(d);
    pll_locked = 1'b0;
    wait_edge(d + 3);

    // Relock with ch0 phase 3, later phase 12 (clamped onto ce).
    r  = d + 5;
    s2 = r + 19;
    x  = s2 + 40;
    dv[0] = 7; dv[1] = 5; dv[2] = 7; dv[3] = 1;
    ph[0] = 3; ph[1] = 0; ph[2] = 0; ph[3] = 5;
    for (int i = 0; i < NCH; i++) anc[i] = s2;
    push(s2, 2, -1);
    gen(s2, s2 + 23);
    ph[0] = 12;
    gen(s2 + 24, x - 1);
    push(x, 3, -1);
    wait_edge(r);
    ph_in[0]   = 4'd3;
    pll_locked = 1'b1;
    wait_edge(s2 + 20);
    ph_in[0] = 4'd12;

    // Asynchronous reset mid-RUN clears outputs without waiting for an edge.
    wait_edge(x);
    rst        = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge refclk);
    #1;

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      $display("FAIL missing_event kind=%0d ch=%0d expected cyc=%0d got nothing", e.kind, e.ch, e.cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
